// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: default geometry and the memory
// port direction encoding.
package store_buffer_pkg;

  localparam int unsigned SB_DEPTH = 4;
  localparam int unsigned SB_AW    = 32;
  localparam int unsigned SB_DW    = 32;
  // Byte-offset bits dropped for word-address matching
  localparam int unsigned WORD_LSB = 2;

  typedef enum logic {
    MEM_WRITE = 1'b0,
    MEM_READ  = 1'b1
  } mem_mode_e;

endpackage

// File: rtl/store_buffer_hazard_cam.sv
// Word-address comparator across all buffered writes plus the write being
// presented this cycle; flags any match against the load word address.
module sb_hazard_cam #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WW    = 30
) (
  input  logic [DEPTH-1:0]         entry_valid_i,
  input  logic [DEPTH-1:0][WW-1:0] entry_word_i,
  input  logic                     wr_valid_i,
  input  logic [WW-1:0]            wr_word_i,
  input  logic [WW-1:0]            ld_word_i,
  output logic                     match_o
);

  always_comb begin
    match_o = wr_valid_i && (wr_word_i == ld_word_i);
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (entry_valid_i[i] && (entry_word_i[i] == ld_word_i)) begin
        match_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// In-order write buffer between the store stage and the data-memory port.
// Loads win the port unless they alias a pending write; otherwise the head drains.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH,
  parameter int unsigned AW    = SB_AW,
  parameter int unsigned DW    = SB_DW
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       wr_valid,
  input  logic [AW-1:0]              wr_addr,
  input  logic [DW-1:0]              wr_data,
  input  logic [DW/8-1:0]            wr_byte_en,
  output logic                       wr_ready,
  input  logic                       ld_req,
  input  logic [AW-1:0]              ld_addr,
  output logic                       ld_hazard,
  input  logic                       fence_req,
  output logic                       fence_stall,
  output logic                       mem_rw_mode,
  output logic [AW-1:0]              mem_addr,
  output logic [DW-1:0]              mem_write_data,
  output logic [DW/8-1:0]            mem_byte_en,
  output logic [$clog2(DEPTH):0]     buf_count
);

  localparam int unsigned BEW = DW / 8;
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned WW  = AW - WORD_LSB;

  typedef struct packed {
    logic           valid;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  data;
    logic [BEW-1:0] be;
  } sb_entry_t;

  sb_entry_t               entries_q [DEPTH];
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q,  count_d;

  logic                    empty_c;
  logic                    push_c;
  logic                    pop_c;
  logic                    load_grant_c;
  logic                    cam_match_c;
  mem_mode_e               mem_mode_c;
  logic [DEPTH-1:0]        entry_valid_c;
  logic [DEPTH-1:0][WW-1:0] entry_word_c;

  assign empty_c     = (count_q == '0);
  assign wr_ready    = (count_q != CW'(DEPTH));
  assign push_c      = wr_valid && wr_ready;
  assign ld_hazard   = ld_req && cam_match_c;
  assign load_grant_c = ld_req && !cam_match_c;
  assign fence_stall = fence_req && !empty_c;
  assign buf_count   = count_q;
  assign mem_rw_mode = mem_mode_c;

  // Flatten entry valid bits and word addresses for the comparator
  always_comb begin
    entry_valid_c = '0;
    entry_word_c  = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      entry_valid_c[i] = entries_q[i].valid;
      entry_word_c[i]  = entries_q[i].addr[AW-1:WORD_LSB];
    end
  end

  sb_hazard_cam #(
    .DEPTH (DEPTH),
    .WW    (WW)
  ) u_hazard_cam (
    .entry_valid_i (entry_valid_c),
    .entry_word_i  (entry_word_c),
    .wr_valid_i    (wr_valid),
    .wr_word_i     (wr_addr[AW-1:WORD_LSB]),
    .ld_word_i     (ld_addr[AW-1:WORD_LSB]),
    .match_o       (cam_match_c)
  );

  // Port arbitration: clean load first, then head drain, else idle read
  always_comb begin
    mem_mode_c     = MEM_READ;
    mem_addr       = '0;
    mem_write_data = '0;
    mem_byte_en    = '0;
    pop_c          = 1'b0;
    if (load_grant_c) begin
      mem_addr = ld_addr;
    end else if (!empty_c) begin
      mem_mode_c     = MEM_WRITE;
      mem_addr       = entries_q[rd_ptr_q].addr;
      mem_write_data = entries_q[rd_ptr_q].data;
      mem_byte_en    = entries_q[rd_ptr_q].be;
      pop_c          = 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d = push_c ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop_c  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push_c) - CW'(pop_c);
  end

  // Push and pop never hit the same slot: push needs !full, pop needs !empty
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (pop_c) begin
        entries_q[rd_ptr_q].valid <= 1'b0;
      end
      if (push_c) begin
        entries_q[wr_ptr_q] <= '{valid: 1'b1, addr: wr_addr, data: wr_data, be: wr_byte_en};
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: reset, drain latency, load priority,
// hazard stall, full-buffer ordering, fence and mid-drain reset.
module tb_store_buffer;

  logic        clk;
  logic        i_rst;
  logic        wr_valid;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_byte_en;
  logic        wr_ready;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic        ld_hazard;
  logic        fence_req;
  logic        fence_stall;
  logic        mem_rw_mode;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_byte_en;
  logic [2:0]  buf_count;

  int checks = 0;
  int errors = 0;

  store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .wr_valid       (wr_valid),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_byte_en     (wr_byte_en),
    .wr_ready       (wr_ready),
    .ld_req         (ld_req),
    .ld_addr        (ld_addr),
    .ld_hazard      (ld_hazard),
    .fence_req      (fence_req),
    .fence_stall    (fence_stall),
    .mem_rw_mode    (mem_rw_mode),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_byte_en    (mem_byte_en),
    .buf_count      (buf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_byte_en = '0;
    ld_req = 1'b0; ld_addr = '0; fence_req = 1'b0;
  endtask

  // Push n words starting at base while a non-aliasing load holds the port
  task automatic fill(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      ld_req = 1'b1; ld_addr = 32'h900;
      wr_valid = 1'b1; wr_addr = base + 32'(4 * i);
      wr_data = 32'hA5A5_0000 | (base + 32'(4 * i)); wr_byte_en = 4'hF;
      step();
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    i_rst = 1'b1;
    step();
    step();
    i_rst = 1'b0;
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
    checks++; if (ld_hazard !== 1'b0) begin errors++; $display("FAIL reset_ld_hazard: got %b want 0", ld_hazard); end
    checks++; if (fence_stall !== 1'b0) begin errors++; $display("FAIL reset_fence_stall: got %b want 0", fence_stall); end
    checks++; if (mem_rw_mode !== 1'b1) begin errors++; $display("FAIL reset_mem_rw_mode: got %b want 1", mem_rw_mode); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    checks++; if (mem_write_data !== 32'h0) begin errors++; $display("FAIL reset_mem_data: got %h want 0", mem_write_data); end
    checks++; if (mem_byte_en !== 4'h0) begin errors++; $display("FAIL reset_mem_be: got %b want 0000", mem_byte_en); end
    checks++; if (buf_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", buf_count); end
  endtask

  task automatic test_single_push();
    wr_valid = 1'b1; wr_addr = 32'h100; wr_data = 32'hAABB_CCDD; wr_byte_en = 4'hF;
    #1;
    checks++; if (mem_rw_mode !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL push_no_bypass: got mode %b addr %h want 1 0", mem_rw_mode, mem_addr); end
    step();
    wr_valid = 1'b0;
    #1;
    checks++; if (buf_count !== 3'd1) begin errors++; $display("FAIL push_count: got %0d want 1", buf_count); end
    checks++; if (mem_rw_mode !== 1'b0) begin errors++; $display("FAIL push_drain_mode: got %b want 0", mem_rw_mode); end
    checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL push_drain_addr: got %h want 100", mem_addr); end
    checks++; if (mem_write_data !== 32'hAABB_CCDD) begin errors++; $display("FAIL push_drain_data: got %h want aabbccdd", mem_write_data); end
    checks++; if (mem_byte_en !== 4'hF) begin errors++; $display("FAIL push_drain_be: got %b want 1111", mem_byte_en); end
    step();
    checks++; if (buf_count !== 3'd0) begin errors++; $display("FAIL push_pop_count: got %0d want 0", buf_count); end
    checks++; if (mem_rw_mode !== 1'b1) begin errors++; $display("FAIL push_idle_mode: got %b want 1", mem_rw_mode); end
  endtask

  task automatic test_load_priority();
    ld_req = 1'b1; ld_addr = 32'h900;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_addr = 32'h300 + 32'(4 * i); wr_data = 32'h1000 + 32'(i); wr_byte_en = 4'hF;
      #1;
      checks++; if (mem_rw_mode !== 1'b1 || mem_addr !== 32'h900) begin errors++; $display("FAIL ld_owns_port[%0d]: got mode %b addr %h want 1 900", i, mem_rw_mode, mem_addr); end
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL ld_fill_ready[%0d]: got %b want 1", i, wr_ready); end
      step();
    end
    wr_addr = 32'h310; wr_data = 32'h1004;
    #1;
    checks++; if (buf_count !== 3'd4) begin errors++; $display("FAIL ld_full_count: got %0d want 4", buf_count); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL ld_full_ready: got %b want 0", wr_ready); end
    checks++; if (ld_hazard !== 1'b0) begin errors++; $display("FAIL ld_no_hazard: got %b want 0", ld_hazard); end
    step();
    checks++; if (buf_count !== 3'd4) begin errors++; $display("FAIL ld_fifth_held: got %0d want 4", buf_count); end
    ld_req = 1'b0; wr_valid = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (mem_rw_mode !== 1'b0 || mem_addr !== 32'h300 + 32'(4 * i)) begin errors++; $display("FAIL ld_drain_addr[%0d]: got mode %b addr %h want 0 %h", i, mem_rw_mode, mem_addr, 32'h300 + 32'(4 * i)); end
      checks++; if (mem_write_data !== 32'h1000 + 32'(i)) begin errors++; $display("FAIL ld_drain_data[%0d]: got %h want %h", i, mem_write_data, 32'h1000 + 32'(i)); end
      step();
    end
    checks++; if (buf_count !== 3'd0 || mem_rw_mode !== 1'b1) begin errors++; $display("FAIL ld_drained: got count %0d mode %b want 0 1", buf_count, mem_rw_mode); end
  endtask

  task automatic test_hazard();
    wr_valid = 1'b1; wr_addr = 32'h204; wr_data = 32'h0000_5500; wr_byte_en = 4'b0010;
    ld_req = 1'b1; ld_addr = 32'h206;
    #1;
    checks++; if (ld_hazard !== 1'b1) begin errors++; $display("FAIL hz_incoming: got %b want 1", ld_hazard); end
    checks++; if (mem_rw_mode !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL hz_idle_port: got mode %b addr %h want 1 0", mem_rw_mode, mem_addr); end
    step();
    wr_valid = 1'b0;
    #1;
    checks++; if (ld_hazard !== 1'b1) begin errors++; $display("FAIL hz_pending: got %b want 1", ld_hazard); end
    checks++; if (mem_rw_mode !== 1'b0 || mem_addr !== 32'h204) begin errors++; $display("FAIL hz_drain: got mode %b addr %h want 0 204", mem_rw_mode, mem_addr); end
    checks++; if (mem_byte_en !== 4'b0010 || mem_write_data !== 32'h0000_5500) begin errors++; $display("FAIL hz_drain_payload: got be %b data %h want 0010 00005500", mem_byte_en, mem_write_data); end
    step();
    checks++; if (ld_hazard !== 1'b0) begin errors++; $display("FAIL hz_cleared: got %b want 0", ld_hazard); end
    checks++; if (mem_rw_mode !== 1'b1 || mem_addr !== 32'h206 || mem_byte_en !== 4'h0) begin errors++; $display("FAIL hz_load_out: got mode %b addr %h be %b want 1 206 0000", mem_rw_mode, mem_addr, mem_byte_en); end
    wr_valid = 1'b1; wr_addr = 32'h20C; wr_data = 32'h1234_5678; wr_byte_en = 4'hF; ld_addr = 32'h208;
    #1;
    checks++; if (ld_hazard !== 1'b0 || mem_addr !== 32'h208) begin errors++; $display("FAIL hz_other_word: got hazard %b addr %h want 0 208", ld_hazard, mem_addr); end
    step();
    wr_valid = 1'b0; ld_req = 1'b0;
    #1;
    checks++; if (mem_rw_mode !== 1'b0 || mem_addr !== 32'h20C) begin errors++; $display("FAIL hz_tail_drain: got mode %b addr %h want 0 20c", mem_rw_mode, mem_addr); end
    step();
    checks++; if (buf_count !== 3'd0) begin errors++; $display("FAIL hz_empty: got %0d want 0", buf_count); end
  endtask

  task automatic test_full_fifo_order();
    logic [31:0] exp_addr [3];
    exp_addr[0] = 32'h18; exp_addr[1] = 32'h1C; exp_addr[2] = 32'h20;
    fill(32'h10, 4);
    ld_req = 1'b0;
    wr_valid = 1'b1; wr_addr = 32'h20; wr_data = 32'hA5A5_0020; wr_byte_en = 4'hF;
    #1;
    checks++; if (buf_count !== 3'd4 || wr_ready !== 1'b0) begin errors++; $display("FAIL full_no_bypass: got count %0d ready %b want 4 0", buf_count, wr_ready); end
    checks++; if (mem_rw_mode !== 1'b0 || mem_addr !== 32'h10) begin errors++; $display("FAIL full_head0: got mode %b addr %h want 0 10", mem_rw_mode, mem_addr); end
    step();
    checks++; if (buf_count !== 3'd3 || wr_ready !== 1'b1) begin errors++; $display("FAIL full_after_pop: got count %0d ready %b want 3 1", buf_count, wr_ready); end
    checks++; if (mem_addr !== 32'h14) begin errors++; $display("FAIL full_head1: got %h want 14", mem_addr); end
    step();
    wr_valid = 1'b0;
    #1;
    checks++; if (buf_count !== 3'd3) begin errors++; $display("FAIL full_push_pop_count: got %0d want 3", buf_count); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (mem_rw_mode !== 1'b0 || mem_addr !== exp_addr[i]) begin errors++; $display("FAIL full_order[%0d]: got mode %b addr %h want 0 %h", i, mem_rw_mode, mem_addr, exp_addr[i]); end
      checks++; if (mem_write_data !== (32'hA5A5_0000 | exp_addr[i])) begin errors++; $display("FAIL full_order_data[%0d]: got %h want %h", i, mem_write_data, 32'hA5A5_0000 | exp_addr[i]); end
      step();
    end
    checks++; if (buf_count !== 3'd0) begin errors++; $display("FAIL full_empty: got %0d want 0", buf_count); end
  endtask

  task automatic test_fence();
    fill(32'h40, 3);
    #1;
    checks++; if (fence_stall !== 1'b0 || buf_count !== 3'd3) begin errors++; $display("FAIL fence_off: got stall %b count %0d want 0 3", fence_stall, buf_count); end
    ld_req = 1'b0; fence_req = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (fence_stall !== 1'b1 || buf_count !== 3'(3 - i)) begin errors++; $display("FAIL fence_hold[%0d]: got stall %b count %0d want 1 %0d", i, fence_stall, buf_count, 3 - i); end
      step();
    end
    checks++; if (fence_stall !== 1'b0 || buf_count !== 3'd0) begin errors++; $display("FAIL fence_release: got stall %b count %0d want 0 0", fence_stall, buf_count); end
    fence_req = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    fill(32'h80, 2);
    ld_req = 1'b0;
    #1;
    checks++; if (mem_rw_mode !== 1'b0 || mem_addr !== 32'h80) begin errors++; $display("FAIL rst_drain_start: got mode %b addr %h want 0 80", mem_rw_mode, mem_addr); end
    step();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    #1;
    checks++; if (buf_count !== 3'd0 || wr_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_count: got count %0d ready %b want 0 1", buf_count, wr_ready); end
    checks++; if (mem_rw_mode !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mid_port: got mode %b addr %h want 1 0", mem_rw_mode, mem_addr); end
    checks++; if (mem_write_data !== 32'h0 || mem_byte_en !== 4'h0) begin errors++; $display("FAIL rst_mid_payload: got data %h be %b want 0 0000", mem_write_data, mem_byte_en); end
    step();
    checks++; if (mem_rw_mode !== 1'b1 || buf_count !== 3'd0) begin errors++; $display("FAIL rst_no_write: got mode %b count %0d want 1 0", mem_rw_mode, buf_count); end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_load_priority();
    test_hazard();
    test_full_fifo_order();
    test_fence();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
